// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 16:1 mux scan sequencer.
// Imported by the controller and its handshake interface users.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int SCAN_STEPS = 16;

  // Step k must address flat bit k of {d,c,b,a}:
  // sel[1:0] picks the bus, sel[3:2] the bit.
  function automatic logic [3:0] sel_swizzle(
    input logic [3:0] step
  );
    return {step[1:0], step[3:2]};
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Valid/ready word handshake into the mux scan sequencer.
// Master drives the word, slave returns ready.
interface mux_scan_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequencer that loads a word onto the mux buses, sweeps sel,
// reads the mux output back and flags any loopback mismatch.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_scan_ctrl_if.slave up,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [3:0]  c,
  output logic [3:0]  d,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        bit_strobe,
  output logic [15:0] rx_word,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DW =
    (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DLAST =
    DW'(DWELL - 1);
  localparam logic [3:0] SLAST =
    4'(SCAN_STEPS - 1);

  state_t        state;
  logic [3:0]    step;
  logic [DW-1:0] dwell;
  logic          last_dw;

  assign last_dw     = (dwell == DLAST);
  assign up.in_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == CHECK);
  // High for the cycle whose closing edge samples mux_out.
  assign bit_strobe  = (state == SCAN) && last_dw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      d       <= '0;
      sel     <= '0;
      rx_word <= '0;
      step    <= '0;
      dwell   <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (up.in_valid) begin
            {d, c, b, a} <= up.in_data;
            rx_word      <= '0;
            err          <= 1'b0;
            step         <= '0;
            dwell        <= '0;
            sel          <= sel_swizzle(4'd0);
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (last_dw) begin
            rx_word[step] <= mux_out;
            dwell         <= '0;
            if (step == SLAST) begin
              step  <= '0;
              state <= CHECK;
            end else begin
              step <= step + 4'd1;
              sel  <= sel_swizzle(step + 4'd1);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        CHECK: begin
          err   <= (rx_word != {d, c, b, a});
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
